// File: rtl/d_input_debouncer_if.sv
// Signal bundle between a bouncy source and the debouncer.
// DEBOUNCE_EVENT_CNT_EN adds the 8-bit debounced edge counter.
interface d_input_debouncer_if;
   logic       raw_in;
   logic       d_out;
   logic       rise_pulse;
   logic       fall_pulse;
   logic       busy;
`ifdef DEBOUNCE_EVENT_CNT_EN
   logic [7:0] event_count;
`endif

   modport master (
      output raw_in,
      input  d_out, rise_pulse, fall_pulse, busy
`ifdef DEBOUNCE_EVENT_CNT_EN
      , input event_count
`endif
   );

   modport slave (
      input  raw_in,
      output d_out, rise_pulse, fall_pulse, busy
`ifdef DEBOUNCE_EVENT_CNT_EN
      , output event_count
`endif
   );
endinterface

// File: rtl/d_input_debouncer.sv
// Synchronizes a bouncy async input, qualifies new levels for STABLE_CYCLES, emits edge pulses.
// Optional DEBOUNCE_EVENT_CNT_EN: 8-bit wrapping count of debounced edges on bus.event_count.
module d_input_debouncer #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4,
   parameter bit RESET_LEVEL   = 1'b0
) (
   input  logic              clock,
   input  logic              reset,
   d_input_debouncer_if.slave bus
);
   localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   generate
      if (SYNC_STAGES < 2) begin : g_bad_sync
         $error("d_input_debouncer: SYNC_STAGES must be >= 2");
      end
      if (STABLE_CYCLES < 1) begin : g_bad_stable
         $error("d_input_debouncer: STABLE_CYCLES must be >= 1");
      end
   endgenerate

   logic [SYNC_STAGES-1:0] stage;
   logic                   sync_val;
   logic                   d_q, d_nxt;
   logic                   rise_q, rise_nxt;
   logic                   fall_q, fall_nxt;
   logic [CNT_W-1:0]       cnt, cnt_nxt;
   logic                   differ;
   logic                   qualify;

   // stage[0] is the only flop that may go metastable
   always_ff @(posedge clock) begin
      if (!reset) stage <= {SYNC_STAGES{RESET_LEVEL}};
      else        stage <= {stage[SYNC_STAGES-2:0], bus.raw_in};
   end

   assign sync_val = stage[SYNC_STAGES-1];
   assign differ   = (sync_val != d_q);
   assign qualify  = differ && (cnt == CNT_LAST);

   always_comb begin
      d_nxt    = d_q;
      cnt_nxt  = '0;
      rise_nxt = 1'b0;
      fall_nxt = 1'b0;
      if (qualify) begin
         d_nxt    = sync_val;
         rise_nxt = sync_val;
         fall_nxt = ~sync_val;
      end else if (differ) begin
         cnt_nxt = cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         d_q    <= RESET_LEVEL;
         cnt    <= '0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         d_q    <= d_nxt;
         cnt    <= cnt_nxt;
         rise_q <= rise_nxt;
         fall_q <= fall_nxt;
      end
   end

   assign bus.d_out      = d_q;
   assign bus.rise_pulse = rise_q;
   assign bus.fall_pulse = fall_q;
   assign bus.busy       = differ;

`ifdef DEBOUNCE_EVENT_CNT_EN
   logic [7:0] ev_q;

   always_ff @(posedge clock) begin
      if (!reset)       ev_q <= 8'd0;
      else if (qualify) ev_q <= ev_q + 8'd1;
   end

   assign bus.event_count = ev_q;
`endif
endmodule

// File: tb/tb_d_input_debouncer.sv
// Randomized scoreboard bench for d_input_debouncer against a history-window reference model.
module tb_d_input_debouncer;
   localparam int S  = 2;
   localparam int C  = 4;
   localparam bit RL = 1'b0;

   logic clock;
   logic reset;
   d_input_debouncer_if bus();

   d_input_debouncer #(.SYNC_STAGES(S), .STABLE_CYCLES(C), .RESET_LEVEL(RL)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      int         cyc;
      logic       d, r, f, b;
      logic [7:0] ec;
      bit         dchk;
      logic       dval;
      bit         echk;
      logic [7:0] eval;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   // Reference model: the raw value S edges ago is the synchronized level; the
   // debounced level flips when the last C synchronized samples all disagree with
   // it and no flip happened within those C edges.
   logic       raw_q[$];
   logic       win[$];
   int         since;
   logic       m_d, m_r, m_f;
   logic [7:0] m_ec;

   function automatic bit window_flips();
      if (win.size() != C || since < C) return 1'b0;
      foreach (win[i]) if (win[i] == m_d) return 1'b0;
      return 1'b1;
   endfunction

   task automatic step(input logic r, input logic rs,
                       input bit dchk = 1'b0, input logic dval = 1'b0,
                       input bit echk = 1'b0, input logic [7:0] eval = 8'd0);
      exp_t e;
      logic s;
      @(negedge clock);
      bus.raw_in = r;
      reset      = rs;
      @(posedge clock);
      cyc++;
      if (!rs) begin
         raw_q = {};
         for (int i = 0; i < S; i++) raw_q.push_back(RL);
         win   = {};
         since = 0;
         m_d   = RL;
         m_r   = 1'b0;
         m_f   = 1'b0;
         m_ec  = 8'd0;
      end else begin
         s = raw_q[S-1];
         raw_q.push_front(r);
         void'(raw_q.pop_back());
         win.push_back(s);
         if (win.size() > C) void'(win.pop_front());
         since++;
         m_r = 1'b0;
         m_f = 1'b0;
         if (window_flips()) begin
            m_d   = ~m_d;
            m_r   = m_d;
            m_f   = ~m_d;
            m_ec  = m_ec + 8'd1;
            since = 0;
         end
      end
      e.cyc  = cyc;
      e.d    = m_d;
      e.r    = m_r;
      e.f    = m_f;
      e.b    = (raw_q[S-1] != m_d);
      e.ec   = m_ec;
      e.dchk = dchk;
      e.dval = dval;
      e.echk = echk;
      e.eval = eval;
      exp_q.push_back(e);
   endtask

   task automatic hold(input logic r, input int n);
      for (int i = 0; i < n; i++) step(r, 1'b1);
   endtask

   always @(negedge clock) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_tests++;
         if ({bus.d_out, bus.rise_pulse, bus.fall_pulse, bus.busy} !== {e.d, e.r, e.f, e.b}) begin
            n_fail++;
            $display("FAIL outputs cyc=%0d d/rise/fall/busy got=%b%b%b%b want=%b%b%b%b", e.cyc,
                     bus.d_out, bus.rise_pulse, bus.fall_pulse, bus.busy, e.d, e.r, e.f, e.b);
         end
         n_tests++;
         if (bus.rise_pulse && bus.fall_pulse) begin
            n_fail++;
            $display("FAIL pulse_excl cyc=%0d rise and fall both high", e.cyc);
         end
         if (e.dchk) begin
            n_tests++;
            if (bus.d_out !== e.dval) begin
               n_fail++;
               $display("FAIL latency cyc=%0d d_out got=%b want=%b", e.cyc, bus.d_out, e.dval);
            end
         end
`ifdef DEBOUNCE_EVENT_CNT_EN
         n_tests++;
         if (bus.event_count !== e.ec) begin
            n_fail++;
            $display("FAIL event_count cyc=%0d got=%0d want=%0d", e.cyc, bus.event_count, e.ec);
         end
         if (e.echk) begin
            n_tests++;
            if (bus.event_count !== e.eval) begin
               n_fail++;
               $display("FAIL event_total cyc=%0d got=%0d want=%0d", e.cyc, bus.event_count, e.eval);
            end
         end
`endif
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic lvl;
      bus.raw_in = 1'b0;
      reset      = 1'b0;
      raw_q = {};
      for (int i = 0; i < S; i++) raw_q.push_back(RL);
      m_d = RL; m_r = 1'b0; m_f = 1'b0; m_ec = 8'd0; since = 0;

      // reset held with raw high, then full latency after release
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, RL);
      for (int k = 1; k <= 8; k++) step(1'b1, 1'b1, (k == 5 || k == 6), (k >= 6));

      // clean rise from a fresh reset
      step(1'b0, 1'b0);
      for (int k = 1; k <= 8; k++) step(1'b1, 1'b1, (k == 5 || k == 6), (k >= 6));
      hold(1'b0, 10);

      // short high pulse must be rejected
      hold(1'b1, 3);
      hold(1'b0, 10);

      // bounce then settle high
      step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b0, 1'b1);
      hold(1'b1, 12);

      // reset in the middle of a falling qualification
      hold(1'b0, 4);
      step(1'b0, 1'b0);
      hold(1'b0, 8);

      // randomized bouncy input with occasional resets
      for (int seg = 0; seg < 300; seg++) begin
         lvl = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 29) == 0) step(lvl, 1'b0);
         hold(lvl, $urandom_range(1, 9));
      end

`ifdef DEBOUNCE_EVENT_CNT_EN
      // three rises and three falls
      step(1'b0, 1'b0);
      for (int t = 0; t < 6; t++) begin
         hold(~t[0], 7);
         step(~t[0], 1'b1, 1'b0, 1'b0, (t == 5), 8'd6);
      end
      // 256 qualified edges wrap the counter to zero
      step(1'b0, 1'b0);
      for (int t = 0; t < 256; t++) begin
         hold(~t[0], 6);
         step(~t[0], 1'b1, 1'b0, 1'b0, (t == 255), 8'd0);
      end
`endif

      hold(1'b0, 3);
      @(negedge clock);
      @(negedge clock);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
